// File: rtl/uc_puzzle_matriz.sv
// -----------------------------------------------------------------------------
// uc_puzzle_matriz
// Control unit for an LED-matrix "lights" puzzle. Plays NUM_NIVEIS levels in
// order: clears the matrix, forwards one button toggle at a time to the
// datapath, checks the datapath's match flag after every move and advances to
// the next level or to the win state.
//
// Optional feature (macro LIMITE_JOGADAS_EN):
//   defined   -> a level that reaches MAX_JOGADAS moves without a match ends
//                the game in DERROTA.
//   undefined -> DERROTA is unreachable, derrota is tied to 0 and the move
//                counter simply saturates at 255.
// -----------------------------------------------------------------------------
module uc_puzzle_matriz #(
    parameter int NUM_NIVEIS  = 4,   // levels played in sequence, 1..8
    parameter int MAX_JOGADAS = 32   // move budget per level, 1..255
) (
    input  logic       clk,
    input  logic       rst,               // synchronous, active-low
    input  logic       iniciar,
    input  logic [7:0] botoes,
    input  logic       nivel_concluido,
    output logic [7:0] botoes_pulso,
    output logic       limpar_matriz,
    output logic [2:0] linha_verificada,
    output logic [2:0] nivel_atual,
    output logic [7:0] jogadas,
    output logic       vitoria,
    output logic       derrota,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LIMPA    = 3'd1,
        JOGANDO  = 3'd2,
        VERIFICA = 3'd3,
        PROXIMO  = 3'd4,
        VITORIA  = 3'd5,
        DERROTA  = 3'd6
    } estado_t;

    localparam logic [2:0] ULTIMO_NIVEL = 3'(NUM_NIVEIS - 1);

    // Parameter sanity: out-of-range values stop elaboration.
    if (NUM_NIVEIS < 1 || NUM_NIVEIS > 8) begin : g_chk_niveis
        $error("uc_puzzle_matriz: NUM_NIVEIS must be in 1..8");
    end
    if (MAX_JOGADAS < 1 || MAX_JOGADAS > 255) begin : g_chk_jogadas
        $error("uc_puzzle_matriz: MAX_JOGADAS must be in 1..255");
    end

    estado_t    estado_q;
    estado_t    estado_d;
    logic [7:0] botoes_q;
    logic [7:0] subida;
    logic [7:0] subida_menor;
    logic       aceita;
    logic       ultimo_nivel;
    logic       limite_atingido;

    logic [2:0] nivel_d;
    logic [7:0] jogadas_d;
    logic [7:0] pulso_d;
    logic       limpar_d;
    logic       vitoria_d;

    // Rising edges of the debounced buttons; only the lowest-index one is
    // forwarded, the others are dropped (two's-complement isolates the LSB).
    assign subida       = botoes & ~botoes_q;
    assign subida_menor = subida & (~subida + 8'd1);
    assign aceita       = (estado_q == JOGANDO) && (subida != 8'd0);
    assign ultimo_nivel = (nivel_atual == ULTIMO_NIVEL);

`ifdef LIMITE_JOGADAS_EN
    assign limite_atingido = (jogadas == 8'(MAX_JOGADAS));
`else
    assign limite_atingido = 1'b0;
`endif

    // The datapath compares the row of the level being played.
    assign linha_verificada = nivel_atual;
    assign estado           = estado_q;

    // State register and button edge register.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            estado_q <= OCIOSO;
            botoes_q <= 8'd0;
        end else begin
            estado_q <= estado_d;
            botoes_q <= botoes;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns estado_d and no latch is
        // inferred; the case only overrides what changes.
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO:   if (iniciar) estado_d = LIMPA;
            LIMPA:    estado_d = JOGANDO;
            JOGANDO:  if (aceita) estado_d = VERIFICA;
            VERIFICA: begin
                // A completed level wins over an exhausted budget.
                if (nivel_concluido)      estado_d = PROXIMO;
                else if (limite_atingido) estado_d = DERROTA;
                else                      estado_d = JOGANDO;
            end
            PROXIMO:  estado_d = ultimo_nivel ? VITORIA : LIMPA;
            VITORIA:  if (iniciar) estado_d = LIMPA;
            DERROTA:  if (iniciar) estado_d = LIMPA;
            default:  estado_d = OCIOSO;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        nivel_d   = nivel_atual;
        jogadas_d = jogadas;
        pulso_d   = aceita ? subida_menor : 8'd0;
        limpar_d  = (estado_d == LIMPA);
        vitoria_d = (estado_d == VITORIA);

        unique case (estado_q)
            OCIOSO, VITORIA, DERROTA: begin
                if (iniciar) nivel_d = 3'd0;
            end
            LIMPA: begin
                jogadas_d = 8'd0;
            end
            JOGANDO: begin
                if (aceita && jogadas != 8'hFF) jogadas_d = jogadas + 8'd1;
            end
            PROXIMO: begin
                if (!ultimo_nivel) nivel_d = nivel_atual + 3'd1;
            end
            default: begin
                nivel_d = nivel_atual;
            end
        endcase
    end

    // Output registers: pulses last exactly the cycle after they are decided.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nivel_atual   <= 3'd0;
            jogadas       <= 8'd0;
            botoes_pulso  <= 8'd0;
            limpar_matriz <= 1'b0;
            vitoria       <= 1'b0;
        end else begin
            nivel_atual   <= nivel_d;
            jogadas       <= jogadas_d;
            botoes_pulso  <= pulso_d;
            limpar_matriz <= limpar_d;
            vitoria       <= vitoria_d;
        end
    end

`ifdef LIMITE_JOGADAS_EN
    // Defeat flag: high for as long as the FSM sits in DERROTA.
    always_ff @(posedge clk) begin
        if (!rst) derrota <= 1'b0;
        else      derrota <= (estado_d == DERROTA);
    end
`else
    assign derrota = 1'b0;
`endif

endmodule
